// File: rtl/mig_write_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mig_write_adapter_pkg
// Purpose  : Shared constants and types for the MIG write adapter: MIG
//            command encodings, request geometry and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mig_write_adapter_pkg;

  // MIG native-port command encodings
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Request geometry: one 768-bit request is 24 words of 32 bits
  localparam int MIG_DATA_W = 32;
  localparam int REQ_BEATS  = 24;
  localparam int REQ_W      = MIG_DATA_W * REQ_BEATS;
  localparam int BURST_W    = 6;

  // Adapter FSM; the state names the phase whose outputs are on the port
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_CMD  = 2'd2,
    ST_DONE = 2'd3
  } wr_state_t;

  // MIG burst-length field is encoded as number of words minus one
  function automatic logic [BURST_W-1:0] burst_field(input int beats);
    return BURST_W'(beats - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mig_write_adapter_beat_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mig_write_adapter_beat_serializer
// Purpose  : Holds one request payload and walks it out word by word.
//            Word k is payload[DATA_W*k +: DATA_W], k = 0 first. The index
//            advances only on step; last flags the final word. While load is
//            high the incoming word 0 is bypassed so it can be issued in the
//            same cycle the payload is captured.
// Revision : 1.0 - initial release
// ============================================================================
module mig_write_adapter_beat_serializer
  import mig_write_adapter_pkg::*;
#(
  parameter int DATA_W = MIG_DATA_W,
  parameter int BEATS  = REQ_BEATS,
  parameter int IDX_W  = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_W*BEATS-1:0] load_data,
  input  logic                    step,
  output logic [DATA_W-1:0]       word,
  output logic                    last
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(BEATS - 1);

  logic [DATA_W*BEATS-1:0] r_data;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_W-1:0]       w_beat [BEATS];
  logic                    w_at_last;

  // Slice the payload register into addressable words
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign w_beat[gi] = r_data[gi*DATA_W +: DATA_W];
  end

  assign w_at_last = (r_idx == C_LAST_IDX);

  // Present the current word, bypassing the input word 0 during a load
  always_comb begin
    word = w_beat[r_idx];
    last = w_at_last;
    if (load) begin
      word = load_data[DATA_W-1:0];
      last = 1'b0;
    end
  end

  // Capture payload on load; advance the word index on each step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_idx  <= '0;
    end else begin
      if (load) begin
        r_data <= load_data;
        r_idx  <= step ? IDX_W'(1) : '0;
      end else if (step) begin
        r_idx  <= w_at_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mig_write_adapter.sv
`default_nettype none
// ============================================================================
// Module   : mig_write_adapter
// Purpose  : Converts one-cycle 768-bit write requests into a MIG native
//            user write: 24 write-data FIFO pushes followed by one write
//            command with burst length 24. Flags per-write completion,
//            dropped requests and MIG write-path errors.
//            All outputs are registered; FIFO-full inputs are sampled on the
//            edge that decides the next cycle's push, so a full flag seen in
//            cycle c suppresses the push in cycle c+1 and the same word is
//            re-presented once full clears.
// Revision : 1.0 - initial release
// ============================================================================
module mig_write_adapter
  import mig_write_adapter_pkg::*;
#(
  parameter int DATA_W = MIG_DATA_W,
  parameter int BEATS  = REQ_BEATS,
  parameter int ADDR_W = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    phy_init_done,
  // request side
  input  logic                    m_write_ram,
  input  logic [DATA_W*BEATS-1:0] m_write_data,
  input  logic [31:0]             m_write_address,
  output logic                    wr_ready,
  // MIG command port
  output logic                    p_cmd_en,
  output logic [2:0]              p_cmd_instr,
  output logic [BURST_W-1:0]      p_cmd_bl,
  output logic [ADDR_W-1:0]       p_cmd_byte_addr,
  input  logic                    p_cmd_full,
  // MIG write-data port
  output logic                    p_wr_en,
  output logic [DATA_W-1:0]       p_wr_data,
  output logic [DATA_W/8-1:0]     p_wr_mask,
  input  logic                    p_wr_full,
  input  logic                    p_wr_error,
  // status
  output logic                    write_done,
  output logic                    drop_err,
  output logic                    mig_err
);

  localparam logic [BURST_W-1:0] C_BURST_BL = burst_field(BEATS);

  wr_state_t          r_state;
  wr_state_t          w_state_next;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wr_last;
  logic               w_accept;
  logic               w_drop;
  logic               w_issue_wr;
  logic               w_issue_cmd;
  logic [DATA_W-1:0]  w_ser_word;
  logic               w_ser_last;
  logic               w_addr_unused;

  // Only a word-aligned byte address inside the MIG space is forwarded
  assign w_addr_unused = ^{m_write_address[31:ADDR_W], m_write_address[1:0]};

  // Only writes are issued and every byte lane is always written
  assign p_cmd_instr = CMD_WRITE;
  assign p_wr_mask   = '0;

  assign w_accept = m_write_ram & wr_ready;
  assign w_drop   = m_write_ram & ~wr_ready;

  mig_write_adapter_beat_serializer #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) u_beat_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (w_accept),
    .load_data (m_write_data),
    .step      (w_issue_wr),
    .word      (w_ser_word),
    .last      (w_ser_last)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and issue decisions; a phase ends once its last output has
  // actually been presented on the port
  always_comb begin
    w_state_next = r_state;
    w_issue_wr   = 1'b0;
    w_issue_cmd  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept)             w_state_next = ST_FILL;
      ST_FILL: if (p_wr_en && r_wr_last) w_state_next = ST_CMD;
      ST_CMD:  if (p_cmd_en)             w_state_next = ST_DONE;
      ST_DONE:                           w_state_next = ST_IDLE;
      default:                           w_state_next = ST_IDLE;
    endcase
    w_issue_wr  = (w_state_next == ST_FILL) && !p_wr_full;
    w_issue_cmd = (w_state_next == ST_CMD)  && !p_cmd_full;
  end

  // Latch the request address, word-aligned, on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= {m_write_address[ADDR_W-1:2], 2'b00};
    end
  end

  // Write-data port: push the serializer's current word when issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_wr_en   <= 1'b0;
      p_wr_data <= '0;
      r_wr_last <= 1'b0;
    end else begin
      p_wr_en   <= w_issue_wr;
      r_wr_last <= w_issue_wr & w_ser_last;
      if (w_issue_wr) begin
        p_wr_data <= w_ser_word;
      end
    end
  end

  // Command port: one write command per request, address only while valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_cmd_en        <= 1'b0;
      p_cmd_bl        <= '0;
      p_cmd_byte_addr <= '0;
    end else begin
      p_cmd_en        <= w_issue_cmd;
      p_cmd_bl        <= w_issue_cmd ? C_BURST_BL : '0;
      p_cmd_byte_addr <= w_issue_cmd ? r_addr : '0;
    end
  end

  // Handshake and status flags; the error flags are sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ready   <= 1'b0;
      write_done <= 1'b0;
      drop_err   <= 1'b0;
      mig_err    <= 1'b0;
    end else begin
      wr_ready   <= (w_state_next == ST_IDLE) && phy_init_done;
      write_done <= (w_state_next == ST_DONE);
      drop_err   <= drop_err | w_drop;
      mig_err    <= mig_err | p_wr_error;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mig_write_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mig_write_adapter
// Purpose  : Directed self-checking bench for mig_write_adapter. Cycle 0 is
//            the cycle in which an accepted request is presented; cycle i is
//            observed at the falling edge i clock periods later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mig_write_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic         phy_init_done;
  logic         m_write_ram;
  logic [767:0] m_write_data;
  logic [31:0]  m_write_address;
  logic         wr_ready;
  logic         p_cmd_en;
  logic [2:0]   p_cmd_instr;
  logic [5:0]   p_cmd_bl;
  logic [29:0]  p_cmd_byte_addr;
  logic         p_cmd_full;
  logic         p_wr_en;
  logic [31:0]  p_wr_data;
  logic [3:0]   p_wr_mask;
  logic         p_wr_full;
  logic         p_wr_error;
  logic         write_done;
  logic         drop_err;
  logic         mig_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] push_data [32];
  int          push_cyc  [32];
  int          n_push, n_cmd, n_done, cmd_cyc, done_cyc, ready_cyc;
  logic [29:0] cmd_addr;
  logic [5:0]  cmd_bl;
  logic [2:0]  cmd_instr;

  logic [767:0] d_nom, d_drop, d_align, d_rst, d_post;
  int           cnt_a, cnt_b;

  always #5 clk = ~clk;

  mig_write_adapter dut (
    .clk             (clk),
    .reset           (reset),
    .phy_init_done   (phy_init_done),
    .m_write_ram     (m_write_ram),
    .m_write_data    (m_write_data),
    .m_write_address (m_write_address),
    .wr_ready        (wr_ready),
    .p_cmd_en        (p_cmd_en),
    .p_cmd_instr     (p_cmd_instr),
    .p_cmd_bl        (p_cmd_bl),
    .p_cmd_byte_addr (p_cmd_byte_addr),
    .p_cmd_full      (p_cmd_full),
    .p_wr_en         (p_wr_en),
    .p_wr_data       (p_wr_data),
    .p_wr_mask       (p_wr_mask),
    .p_wr_full       (p_wr_full),
    .p_wr_error      (p_wr_error),
    .write_done      (write_done),
    .drop_err        (drop_err),
    .mig_err         (mig_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [767:0] make_data(input logic [31:0] base, input logic [31:0] stride);
    logic [767:0] d;
    for (int k = 0; k < 24; k++) d[k*32 +: 32] = base + 32'(k) * stride;
    return d;
  endfunction

  // Present one request at cycle 0 and record port activity for cycles 1..60.
  // Full flags are driven high for the listed cycles; extra_at raises a
  // second request; phy_drop_at lowers phy_init_done.
  task automatic run_req(input logic [31:0] addr, input logic [767:0] data,
                         input int f_lo, input int f_hi, input int c_lo, input int c_hi,
                         input int extra_at, input int phy_drop_at);
    @(negedge clk);
    chk("ready_before_req", wr_ready, 1);
    m_write_ram = 1'b1;
    m_write_data = data;
    m_write_address = addr;
    n_push = 0; n_cmd = 0; n_done = 0;
    cmd_cyc = -1; done_cyc = -1; ready_cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      m_write_ram = (i == extra_at);
      if (i == 1) m_write_data = ~data;
      if (p_wr_en) begin
        if (n_push < 32) begin
          push_data[n_push] = p_wr_data;
          push_cyc[n_push]  = i;
        end
        n_push++;
      end
      if (p_cmd_en) begin
        n_cmd++; cmd_cyc = i;
        cmd_addr = p_cmd_byte_addr; cmd_bl = p_cmd_bl; cmd_instr = p_cmd_instr;
      end
      if (write_done) begin
        n_done++; done_cyc = i;
      end
      if (wr_ready && ready_cyc < 0) ready_cyc = i;
      p_wr_full  = (i >= f_lo && i <= f_hi);
      p_cmd_full = (i >= c_lo && i <= c_hi);
      if (i == phy_drop_at) phy_init_done = 1'b0;
    end
    m_write_ram = 1'b0;
    m_write_data = '0;
    p_wr_full = 1'b0;
    p_cmd_full = 1'b0;
  endtask

  task automatic check_words(input string tag, input logic [767:0] data);
    chk({tag, "_push_count"}, n_push, 24);
    for (int k = 0; k < 24; k++)
      chk($sformatf("%s_word%0d", tag, k), push_data[k], data[k*32 +: 32]);
  endtask

  initial begin
    reset = 1'b1; phy_init_done = 1'b1; m_write_ram = 1'b0; m_write_data = '0;
    m_write_address = '0; p_cmd_full = 1'b0; p_wr_full = 1'b0; p_wr_error = 1'b0;
    d_nom   = make_data(32'hA500_0000, 32'h1);
    d_drop  = make_data(32'h3C00_0000, 32'h11);
    d_align = make_data(32'h0102_0304, 32'h0101_0101);
    d_rst   = make_data(32'hDEAD_0000, 32'h3);
    d_post  = make_data(32'h5A5A_0000, 32'h100);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_p_wr_en", p_wr_en, 0);
    chk("rst_p_wr_data", p_wr_data, 0);
    chk("rst_p_cmd_en", p_cmd_en, 0);
    chk("rst_p_cmd_bl", p_cmd_bl, 0);
    chk("rst_p_cmd_addr", p_cmd_byte_addr, 0);
    chk("rst_p_cmd_instr", p_cmd_instr, 0);
    chk("rst_p_wr_mask", p_wr_mask, 0);
    chk("rst_write_done", write_done, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_mig_err", mig_err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", wr_ready, 1);

    // Nominal write
    run_req(32'h0000_0100, d_nom, -1, -1, -1, -1, -1, -1);
    check_words("nom", d_nom);
    chk("nom_first_push_cyc", push_cyc[0], 1);
    chk("nom_last_push_cyc", push_cyc[23], 24);
    chk("nom_cmd_count", n_cmd, 1);
    chk("nom_cmd_cyc", cmd_cyc, 25);
    chk("nom_cmd_bl", cmd_bl, 23);
    chk("nom_cmd_addr", cmd_addr, 30'h100);
    chk("nom_cmd_instr", cmd_instr, 0);
    chk("nom_done_count", n_done, 1);
    chk("nom_done_cyc", done_cyc, 26);
    chk("nom_ready_cyc", ready_cyc, 27);
    chk("nom_drop_err", drop_err, 0);

    // Data backpressure: pushes 5..9 suppressed, word 4 resumes at cycle 10
    run_req(32'h0000_0400, d_nom, 4, 8, -1, -1, -1, -1);
    check_words("wbp", d_nom);
    chk("wbp_word3_cyc", push_cyc[3], 4);
    chk("wbp_word4_cyc", push_cyc[4], 10);
    chk("wbp_last_push_cyc", push_cyc[23], 29);
    chk("wbp_cmd_cyc", cmd_cyc, 30);
    chk("wbp_done_cyc", done_cyc, 31);

    // Command backpressure: three full cycles at CMD entry
    run_req(32'h0000_0800, d_nom, -1, -1, 24, 26, -1, -1);
    chk("cbp_cmd_count", n_cmd, 1);
    chk("cbp_cmd_cyc", cmd_cyc, 28);
    chk("cbp_cmd_addr", cmd_addr, 30'h800);
    chk("cbp_done_cyc", done_cyc, 29);

    // Dropped request during FILL
    run_req(32'h0000_0200, d_drop, -1, -1, -1, -1, 5, -1);
    check_words("drop", d_drop);
    chk("drop_err_set", drop_err, 1);
    chk("drop_cmd_count", n_cmd, 1);
    chk("drop_cmd_addr", cmd_addr, 30'h200);
    chk("drop_done_count", n_done, 1);
    chk("drop_done_cyc", done_cyc, 26);

    // Unaligned address, phy_init_done falls mid-transfer
    run_req(32'h0000_0103, d_align, -1, -1, -1, -1, -1, 10);
    check_words("aln", d_align);
    chk("aln_cmd_addr", cmd_addr, 30'h100);
    chk("aln_done_cyc", done_cyc, 26);
    chk("aln_ready_held_low", ready_cyc, -1);
    phy_init_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("aln_ready_after_phy", wr_ready, 1);

    // Calibration gating
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    phy_init_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("cal_ready_low", wr_ready, 0);
    chk("cal_drop_clear", drop_err, 0);
    m_write_ram = 1'b1; m_write_data = d_nom; m_write_address = 32'h100;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      m_write_ram = 1'b0;
      if (p_wr_en || p_cmd_en) cnt_a++;
      if (wr_ready) cnt_b++;
    end
    chk("cal_no_mig_activity", cnt_a, 0);
    chk("cal_ready_never", cnt_b, 0);
    chk("cal_drop_err", drop_err, 1);
    phy_init_done = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-operation at beat 10
    chk("mr_ready", wr_ready, 1);
    m_write_ram = 1'b1; m_write_data = d_rst; m_write_address = 32'h300;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      m_write_ram = 1'b0;
    end
    chk("mr_pre_wr_en", p_wr_en, 1);
    chk("mr_pre_word9", p_wr_data, 32'hDEAD_001B);
    #2 reset = 1'b1;
    #1;
    chk("mr_async_wr_en", p_wr_en, 0);
    chk("mr_async_wr_data", p_wr_data, 0);
    chk("mr_async_drop_err", drop_err, 0);
    chk("mr_async_ready", wr_ready, 0);
    repeat (3) @(negedge clk);
    chk("mr_hold_wr_en", p_wr_en, 0);
    chk("mr_hold_cmd_en", p_cmd_en, 0);
    chk("mr_hold_done", write_done, 0);
    chk("mr_hold_ready", wr_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_ready_after", wr_ready, 1);
    run_req(32'h0000_0500, d_post, -1, -1, -1, -1, -1, -1);
    check_words("post", d_post);
    chk("post_cmd_addr", cmd_addr, 30'h500);
    chk("post_cmd_cyc", cmd_cyc, 25);
    chk("post_done_cyc", done_cyc, 26);

    // MIG error flag is sticky
    chk("mig_err_clear", mig_err, 0);
    @(negedge clk);
    p_wr_error = 1'b1;
    @(negedge clk);
    p_wr_error = 1'b0;
    chk("mig_err_set", mig_err, 1);
    repeat (3) @(negedge clk);
    chk("mig_err_sticky", mig_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mig_write_adapter.md
Name: mig_write_adapter

Overview:
- Downstream of ram_initiator.
- Consumes its 768-bit write requests (m_write_ram / m_write_data / m_write_address) and drives one MIG native user write port (32-bit data path).
- Each accepted request is serialised into 24 data-FIFO pushes followed by one write command with burst length 24.
- Reports per-write completion, dropped requests and MIG data errors.

Parameters:
- DATA_W, 32, MIG port data width in bits.
- BEATS, 24, words per request; DATA_W*BEATS must equal 768.
- ADDR_W, 30, MIG byte-address width.

Ports:
- clk  input  1  system clock; every flop clocked on rising edge.
- reset  input  1  asynchronous, active-high reset.
- phy_init_done  input  1  MIG calibration complete.
- m_write_ram  input  1  write request strobe, one cycle per request.
- m_write_data  input  768  request payload.
- m_write_address  input  32  request byte address; bits [ADDR_W-1:0] used.
- wr_ready  output  1  adapter can accept a request this cycle.
- p_cmd_en  output  1  MIG command push.
- p_cmd_instr  output  3  MIG command; always 3'b000 (write).
- p_cmd_bl  output  6  burst length minus one; BEATS-1 (23) while p_cmd_en.
- p_cmd_byte_addr  output  ADDR_W  command byte address.
- p_cmd_full  input  1  MIG command FIFO full.
- p_wr_en  output  1  MIG write-data push.
- p_wr_data  output  DATA_W  write data word.
- p_wr_mask  output  DATA_W/8  byte mask; always 0.
- p_wr_full  input  1  MIG write-data FIFO full.
- p_wr_error  input  1  MIG write-path error.
- write_done  output  1  one-cycle pulse when the command for a request is pushed.
- drop_err  output  1  sticky: request arrived while wr_ready=0.
- mig_err  output  1  sticky: p_wr_error seen high.

Behaviour:
- Reset values:
  - All outputs 0, except p_cmd_instr=3'b000 and p_cmd_bl=0.
  - FSM in IDLE, beat counter 0, payload/address registers 0.
- Output timing: all outputs registered. wr_ready is registered from the next state and phy_init_done.
- Acceptance:
  - wr_ready = 1 only in IDLE with phy_init_done=1.
  - A request is accepted when m_write_ram=1 and wr_ready=1.
  - On acceptance, m_write_data and m_write_address are latched. The latched address has bits [1:0] forced to 0, so the command is word-aligned.
  - wr_ready drops the next cycle.
- Dropped requests: m_write_ram=1 while wr_ready=0 is discarded, sets drop_err, and does not disturb the transfer in progress.
- FSM states and transitions:
  - IDLE -> FILL on acceptance.
  - FILL: p_wr_en=1 with p_wr_data = payload word k = latched data[32k+31:32k], k = 0..23 in order, k=0 first. The beat counter advances only when a push occurs. p_wr_en is held low on any cycle where p_wr_full=1, and the same word is re-presented once full deasserts (no word skipped or duplicated). After the push of k=23, go to CMD.
  - CMD: p_cmd_en=1 with p_cmd_bl=23 and p_cmd_byte_addr = latched address, asserted on the first cycle with p_cmd_full=0. Exactly one p_cmd_en pulse per request. Then go to DONE.
  - DONE: write_done=1 for one cycle, then IDLE.
- Latency with no backpressure, acceptance at cycle 0:
  - p_wr_en high cycles 1..24.
  - p_cmd_en cycle 25.
  - write_done cycle 26.
  - wr_ready high again cycle 27.
- phy_init_done:
  - Falling mid-transfer does not abort; the transfer completes.
  - wr_ready stays 0 until phy_init_done returns to 1.
- Error flags: mig_err sets on any cycle with p_wr_error=1. drop_err and mig_err clear only on reset.
- Reset mid-operation: asynchronous return to reset values. Words already pushed to the MIG are not retracted; the MIG port is reset from the same reset net.
- Back-to-back requests: minimum spacing between accepted requests is 27 cycles.

Decomposition:
- Shared package/header:
  - MIG command encodings (CMD_WRITE=3'b000, CMD_READ=3'b001).
  - Request width 768, BEATS 24, DATA_W 32.
  - FSM state encodings IDLE/FILL/CMD/DONE.
- One natural sub-module, beat_serializer: a 768-bit load register plus beat counter producing word k, with a step input (push) and a last flag (k==23). The FSM stays in mig_write_adapter.

Test Plan:
- Nominal write:
  - Stimulus: phy_init_done=1; one request with address 0x0000_0100 and data = word k = 0xA5000000+k.
  - Required response: 24 p_wr_en pushes carrying 0xA5000000..0xA5000017 in order, then p_cmd_en with bl=23 and addr=0x100 at cycle 25, write_done at cycle 26.
- Data backpressure:
  - Stimulus: p_wr_full=1 during cycles 5..9.
  - Required response: pushes pause with p_wr_en=0; word 4 re-presented on resume; all 24 words exactly once; write_done at cycle 31.
- Command backpressure:
  - Stimulus: p_cmd_full=1 for 3 cycles at CMD entry.
  - Required response: single p_cmd_en on the first non-full cycle; write_done the next cycle.
- Dropped request and alignment:
  - Stimulus: second m_write_ram during FILL; separately, a request with address 0x0000_0103.
  - Required response: drop_err=1, first transfer intact, no extra command; the second case issues cmd addr 0x100.
- Calibration gating:
  - Stimulus: phy_init_done=0 with a request.
  - Required response: wr_ready=0, no p_wr_en, drop_err=1.
- Reset mid-operation:
  - Stimulus: reset asserted during FILL at beat 10.
  - Required response: outputs go to reset values asynchronously and stay there while reset is held; a fresh request afterwards completes normally.
